// File: rtl/red_pitaya_sort_pulser.sv
// Sort pulser: qualifies detector triggers and issues a delayed ASG strobe plus sort gate, then a hold-off.
// Defining SORT_PULSER_DROP_CNT_EN builds the saturating drop counter; otherwise drop_cnt_o is tied to 0.
module red_pitaya_sort_pulser #(
    parameter int CW = 32,
    parameter int QW = 16
) (
    input  logic          adc_clk_i,
    input  logic          adc_rst_i,
    input  logic          sort_trig_i,
    input  logic          enable_i,
    input  logic [QW-1:0] min_high_i,
    input  logic [CW-1:0] delay_i,
    input  logic [CW-1:0] width_i,
    input  logic [CW-1:0] holdoff_i,
    output logic          asg_trig_o,
    output logic          gate_o,
    output logic          busy_o,
    output logic [CW-1:0] sort_cnt_o,
    output logic [CW-1:0] drop_cnt_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        QUAL  = 3'd1,
        DELAY = 3'd2,
        PULSE = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          trig_q, trig_qq, rise;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [QW-1:0] m_q, m_d;
    logic [QW-1:0] m_eff;
    logic [CW-1:0] w_eff;
    logic          gate_d, asg_d, sort_inc, drop_inc;

    assign rise  = trig_q & ~trig_qq;
    assign m_eff = (min_high_i == '0) ? QW'(1) : min_high_i;
    assign w_eff = (width_i == '0) ? CW'(1) : width_i;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        qcnt_d   = qcnt_q;
        m_d      = m_q;
        gate_d   = 1'b0;
        asg_d    = 1'b0;
        sort_inc = 1'b0;
        drop_inc = 1'b0;

        if (!enable_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rise) begin
                        m_d = m_eff;
                        if (m_eff == QW'(1)) begin
                            state_d = DELAY;
                            cnt_d   = delay_i;
                        end else begin
                            state_d = QUAL;
                            qcnt_d  = QW'(1);
                        end
                    end
                end
                QUAL: begin
                    if (trig_q) begin
                        qcnt_d = qcnt_q + QW'(1);
                        if (qcnt_q + QW'(1) == m_q) begin
                            state_d = DELAY;
                            cnt_d   = delay_i;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                DELAY: begin
                    drop_inc = rise;
                    if (cnt_q == '0) begin
                        state_d  = PULSE;
                        gate_d   = 1'b1;
                        asg_d    = 1'b1;
                        sort_inc = 1'b1;
                        cnt_d    = w_eff - CW'(1);
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                PULSE: begin
                    drop_inc = rise;
                    if (cnt_q == '0) begin
                        state_d = HOLD;
                        cnt_d   = holdoff_i;
                    end else begin
                        gate_d = 1'b1;
                        cnt_d  = cnt_q - CW'(1);
                    end
                end
                HOLD: begin
                    drop_inc = rise;
                    if (cnt_q == '0) state_d = IDLE;
                    else             cnt_d   = cnt_q - CW'(1);
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            state_q    <= IDLE;
            trig_q     <= 1'b0;
            trig_qq    <= 1'b0;
            cnt_q      <= '0;
            qcnt_q     <= '0;
            m_q        <= '0;
            gate_o     <= 1'b0;
            asg_trig_o <= 1'b0;
            busy_o     <= 1'b0;
            sort_cnt_o <= '0;
        end else begin
            state_q    <= state_d;
            trig_q     <= sort_trig_i;
            trig_qq    <= trig_q;
            cnt_q      <= cnt_d;
            qcnt_q     <= qcnt_d;
            m_q        <= m_d;
            gate_o     <= gate_d;
            asg_trig_o <= asg_d;
            busy_o     <= (state_d != IDLE);
            if (sort_inc) sort_cnt_o <= sort_cnt_o + CW'(1);
        end
    end

`ifdef SORT_PULSER_DROP_CNT_EN
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i)                         drop_cnt_o <= '0;
        else if (drop_inc && drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + CW'(1);
    end
`else
    logic unused_drop_inc;
    assign unused_drop_inc = drop_inc;
    assign drop_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_red_pitaya_sort_pulser.sv
// Bench for red_pitaya_sort_pulser: table vectors, hand sequences and a timeline reference model.
module tb_red_pitaya_sort_pulser;

    localparam int CW = 8;
    localparam int QW = 16;
    localparam int CMAX = (1 << CW) - 1;
`ifdef SORT_PULSER_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          adc_rst = 1'b0;
    logic          sort_trig = 1'b0;
    logic          enable = 1'b1;
    logic [QW-1:0] min_high = '0;
    logic [CW-1:0] delay = '0, width = '0, holdoff = '0;
    logic          asg_trig_o, gate_o, busy_o;
    logic [CW-1:0] sort_cnt_o, drop_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    red_pitaya_sort_pulser #(.CW(CW), .QW(QW)) dut (
        .adc_clk_i  (clk),
        .adc_rst_i  (adc_rst),
        .sort_trig_i(sort_trig),
        .enable_i   (enable),
        .min_high_i (min_high),
        .delay_i    (delay),
        .width_i    (width),
        .holdoff_i  (holdoff),
        .asg_trig_o (asg_trig_o),
        .gate_o     (gate_o),
        .busy_o     (busy_o),
        .sort_cnt_o (sort_cnt_o),
        .drop_cnt_o (drop_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: an accepted event is a timeline of milestone edges computed from the rules.
    bit     model_chk = 1'b0;
    bit     m_tq, m_tqq, m_active, m_qual;
    longint m_t = 0, m_a, m_tgate, m_tgend, m_tidle;
    int     m_m;
    int     exp_gate, exp_asg, exp_busy, exp_sort, exp_drop;

    function automatic void model_step();
        bit rise_m;
        rise_m = m_tq && !m_tqq;
        m_t++;
        if (adc_rst) begin
            m_tq = 0; m_tqq = 0; m_active = 0; m_qual = 0;
            exp_gate = 0; exp_asg = 0; exp_busy = 0; exp_sort = 0; exp_drop = 0;
            return;
        end
        exp_asg = 0;
        if (!enable) begin
            m_active = 0;
            exp_gate = 0;
        end else if (!m_active) begin
            if (rise_m) begin
                m_active = 1;
                m_a      = m_t;
                m_m      = (min_high == 0) ? 1 : int'(min_high);
                m_tgend  = -1;
                m_tidle  = -1;
                m_qual   = (m_m != 1);
                if (!m_qual) m_tgate = m_t + 1 + longint'(delay);
            end
        end else if (m_qual) begin
            if (!m_tq) m_active = 0;
            else if (m_t == m_a + m_m - 1) begin
                m_qual  = 0;
                m_tgate = m_t + 1 + longint'(delay);
            end
        end else begin
            if (rise_m && DROP_EN && exp_drop < CMAX) exp_drop++;
            if (m_t == m_tgate) begin
                exp_gate = 1;
                exp_asg  = 1;
                exp_sort = (exp_sort + 1) % (CMAX + 1);
                m_tgend  = m_t + ((width == 0) ? 1 : longint'(width));
            end else if (m_t == m_tgend) begin
                exp_gate = 0;
                m_tidle  = m_t + longint'(holdoff) + 1;
            end else if (m_t == m_tidle) begin
                m_active = 0;
            end
        end
        exp_busy = m_active;
        m_tqq = m_tq;
        m_tq  = sort_trig;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (model_chk) begin
            check("rnd_gate", gate_o, exp_gate);
            check("rnd_asg", asg_trig_o, exp_asg);
            check("rnd_busy", busy_o, exp_busy);
            check("rnd_sort", sort_cnt_o, exp_sort);
            check("rnd_drop", drop_cnt_o, exp_drop);
        end
    endtask

    task automatic do_reset();
        adc_rst = 1'b1;
        tick();
        tick();
        adc_rst = 1'b0;
        tick();
    endtask

    task automatic set_cfg(input int m, input int d, input int w, input int h);
        min_high = QW'(m);
        delay    = CW'(d);
        width    = CW'(w);
        holdoff  = CW'(h);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    typedef struct {
        int m, d, w, h;
        int len, window;
        int exp_edge, exp_len, busy_low_by;
    } vec_t;

    vec_t vecs[7];
    int   exp_sort_d;

    initial begin
        int gate_edge, gate_len, asg_n, busy_at, run_left;

        vecs[0] = '{1, 0,  1, 0, 3,    12,    2, 1, 5};
        vecs[1] = '{4, 10, 5, 0, 3,    20,   -1, 0, 6};
        vecs[2] = '{4, 10, 5, 0, 6,    30,   15, 5, 22};
        vecs[3] = '{0, 3,  0, 2, 1,    16,    5, 1, 10};
        vecs[4] = '{2, 0,  3, 1, 2,    14,    3, 3, 9};
        vecs[5] = '{2, 0,  3, 1, 1,    10,   -1, 0, 4};
        vecs[6] = '{1, 0,  2, 0, 1000, 1010,  2, 2, 6};

        adc_rst = 1'b1;
        tick();
        check("rst_gate", gate_o, 0);
        check("rst_asg", asg_trig_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_sort", sort_cnt_o, 0);
        check("rst_drop", drop_cnt_o, 0);
        adc_rst = 1'b0;
        idle(3);

        exp_sort_d = 0;
        for (int v = 0; v < 7; v++) begin
            set_cfg(vecs[v].m, vecs[v].d, vecs[v].w, vecs[v].h);
            idle(4);
            gate_edge = -1; gate_len = 0; asg_n = 0; busy_at = -1;
            sort_trig = 1'b1;
            for (int k = 0; k < vecs[v].window; k++) begin
                tick();
                if (k == vecs[v].len - 1) sort_trig = 1'b0;
                if (gate_o && gate_edge < 0) gate_edge = k;
                if (gate_o) gate_len++;
                if (asg_trig_o) asg_n++;
                if (k == vecs[v].busy_low_by) busy_at = int'(busy_o);
            end
            if (vecs[v].exp_edge >= 0) exp_sort_d++;
            check($sformatf("vec%0d_gate_edge", v), gate_edge, vecs[v].exp_edge);
            check($sformatf("vec%0d_gate_len", v), gate_len, vecs[v].exp_len);
            check($sformatf("vec%0d_asg_count", v), asg_n, (vecs[v].exp_edge >= 0) ? 1 : 0);
            check($sformatf("vec%0d_busy_low", v), busy_at, 0);
            check($sformatf("vec%0d_sort_cnt", v), sort_cnt_o, exp_sort_d);
        end

        // Second rise 30 cycles into a long event is dropped.
        do_reset();
        set_cfg(1, 100, 50, 20);
        asg_n = 0;
        for (int k = 0; k < 200; k++) begin
            sort_trig = (k < 2) || (k >= 30 && k < 32);
            tick();
            if (asg_trig_o) asg_n++;
        end
        sort_trig = 1'b0;
        check("drop_asg_count", asg_n, 1);
        check("drop_sort_cnt", sort_cnt_o, 1);
        check("drop_drop_cnt", drop_cnt_o, DROP_EN ? 1 : 0);
        check("drop_busy_end", busy_o, 0);

        // Disable during PULSE aborts on the next edge.
        do_reset();
        set_cfg(1, 2, 10, 0);
        sort_trig = 1'b1;
        tick();
        sort_trig = 1'b0;
        for (int i = 0; i < 20 && gate_o !== 1'b1; i++) tick();
        check("en_gate_seen", gate_o, 1);
        idle(2);
        enable = 1'b0;
        tick();
        check("en_abort_gate", gate_o, 0);
        check("en_abort_asg", asg_trig_o, 0);
        check("en_abort_busy", busy_o, 0);
        check("en_abort_sort", sort_cnt_o, 1);
        enable = 1'b1;
        tick();
        check("en_after_gate", gate_o, 0);

        // Reset during DELAY clears everything, including a pending drop.
        set_cfg(1, 50, 3, 0);
        sort_trig = 1'b1;
        tick();
        sort_trig = 1'b0;
        idle(2);
        sort_trig = 1'b1;
        tick();
        sort_trig = 1'b0;
        idle(2);
        check("rd_busy_pre", busy_o, 1);
        check("rd_drop_pre", drop_cnt_o, DROP_EN ? 1 : 0);
        adc_rst = 1'b1;
        tick();
        check("rd_gate", gate_o, 0);
        check("rd_asg", asg_trig_o, 0);
        check("rd_busy", busy_o, 0);
        check("rd_sort", sort_cnt_o, 0);
        check("rd_drop", drop_cnt_o, 0);
        adc_rst = 1'b0;
        tick();

        // sort_cnt_o wraps after 2^CW actuations.
        set_cfg(1, 0, 1, 0);
        for (int e = 0; e < CMAX; e++) begin
            sort_trig = 1'b1;
            tick();
            sort_trig = 1'b0;
            idle(6);
        end
        check("wrap_sort_full", sort_cnt_o, CMAX);
        sort_trig = 1'b1;
        tick();
        sort_trig = 1'b0;
        idle(6);
        check("wrap_sort_zero", sort_cnt_o, 0);

        // drop_cnt_o saturates and stays at all-ones.
        do_reset();
        set_cfg(1, CMAX, CMAX, CMAX);
        for (int k = 0; k < 600; k++) begin
            sort_trig = (k % 2 == 0);
            tick();
        end
        sort_trig = 1'b0;
        for (int i = 0; i < 400 && busy_o !== 1'b0; i++) tick();
        check("sat_busy_end", busy_o, 0);
        check("sat_drop_full", drop_cnt_o, DROP_EN ? CMAX : 0);
        tick();
        sort_trig = 1'b1;
        tick();
        sort_trig = 1'b0;
        idle(3);
        sort_trig = 1'b1;
        tick();
        sort_trig = 1'b0;
        for (int i = 0; i < 900 && busy_o !== 1'b0; i++) tick();
        check("sat_busy_end2", busy_o, 0);
        check("sat_drop_hold", drop_cnt_o, DROP_EN ? CMAX : 0);
        check("sat_sort", sort_cnt_o, 2);

        // Randomised traffic against the reference model.
        do_reset();
        model_chk = 1'b1;
        run_left  = 0;
        for (int c = 0; c < 4000; c++) begin
            if (run_left == 0) begin
                sort_trig = ~sort_trig;
                run_left  = int'($urandom_range(1, 8));
            end
            run_left--;
            if ($urandom_range(0, 39) == 0) begin
                min_high = QW'($urandom_range(0, 4));
                delay    = CW'($urandom_range(0, 6));
                width    = CW'($urandom_range(0, 4));
                holdoff  = CW'($urandom_range(0, 4));
            end
            enable  = ($urandom_range(0, 149) != 0);
            adc_rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        model_chk = 1'b0;
        adc_rst   = 1'b0;
        enable    = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/red_pitaya_sort_pulser.md
Name: red_pitaya_sort_pulser

Overview:
- Consumes the sort trigger level from the FADS fluorescence detector and turns each qualified detection into a timed sort actuation.
- Output is a one-cycle ASG trigger plus a gate held for a programmed width, after a programmed droplet travel delay.
- Enforces a hold-off between actuations and keeps event counters for the register bank.
- Sits between the detector and the ASG/HV-amplifier trigger path in the ADC clock domain.

Parameters:
- CW, 32, width of delay/width/hold-off configuration words and of both event counters
- QW, 16, width of the minimum-high qualification word

Ports:
- adc_clk_i  in  1  ADC clock, single clock domain
- adc_rst_i  in  1  synchronous reset, active-high
- sort_trig_i  in  1  detector sort trigger level
- enable_i  in  1  sorting enable
- min_high_i  in  QW  consecutive high cycles required to qualify a detection; 0 is treated as 1
- delay_i  in  CW  cycles from qualification to actuation
- width_i  in  CW  gate_o high time in cycles; 0 is treated as 1
- holdoff_i  in  CW  dead time in cycles after the gate ends
- asg_trig_o  out  1  one-cycle ASG trigger strobe
- gate_o  out  1  sort gate, high for the width duration
- busy_o  out  1  high in any state other than IDLE
- sort_cnt_o  out  CW  number of actuations issued (wraps)
- drop_cnt_o  out  CW  number of rising edges ignored while busy (saturates)

Behaviour:
- Reset: every output is 0. The FSM enters IDLE. All internal counters and the input sample registers are cleared.
- Input path: sort_trig_i is registered into trig_q, then into trig_qq. The rising-edge signal is rise = trig_q & ~trig_qq.
- States: IDLE, QUAL, DELAY, PULSE, HOLD. All outputs are registered.
- IDLE: a rise with enable_i=1 starts a detection.
  - If effective M (min_high) is 1, go to DELAY and load cnt <= delay_i.
  - Otherwise go to QUAL with qcnt <= 1.
  - A stuck-high input never retriggers; a new rise is required.
- QUAL:
  - If trig_q=1, qcnt increments; when qcnt+1 == M, go to DELAY and load cnt <= delay_i.
  - If trig_q=0, return to IDLE. This is a rejected detection: no counter changes.
- DELAY:
  - If cnt==0, go to PULSE: assert gate_o and asg_trig_o, increment sort_cnt_o, load cnt <= effective width-1.
  - Otherwise decrement cnt.
- PULSE:
  - asg_trig_o is high only on the first PULSE cycle.
  - gate_o stays high; when cnt==0, drop gate_o and go to HOLD with cnt <= holdoff_i. Otherwise decrement cnt.
- HOLD: if cnt==0, go to IDLE; otherwise decrement cnt. With holdoff_i=0 there is exactly one HOLD cycle.
- Latency: let E be the first clock edge sampling sort_trig_i=1. The gate_o/asg_trig_o rising edge is at edge E+1+M+D, where D=delay_i. For M=1, D=0 this is E+2.
- gate_o is high for exactly max(width_i,1) cycles.
- Config inputs are sampled only at the moment they are loaded. Changes mid-event take effect from the next load.
- Drops: a rise in DELAY, PULSE or HOLD increments drop_cnt_o, saturating at all-ones. A rise in QUAL cannot occur because trig_q is still high.
- enable_i=0 in any state: abort to IDLE on the next edge and clear gate_o/asg_trig_o. Counters are unchanged.
- Simultaneous events:
  - sort_cnt_o wraps modulo 2^CW.
  - A rise on the same cycle the FSM returns to IDLE is counted as dropped, not accepted.
- Reset mid-operation: all outputs clear on the next edge; the pending event is discarded.

Optional Feature:
- Macro: SORT_PULSER_DROP_CNT_EN.
- Defined: drop_cnt_o counts as described above.
- Undefined: the drop counter logic is omitted and drop_cnt_o is tied to 0. All other behaviour is identical.

Test Plan:
- M=1, D=0, W=1, H=0; single 3-cycle high on sort_trig_i: gate_o and asg_trig_o high at E+2 for 1 cycle; busy_o low from E+5; sort_cnt_o=1.
- M=4, D=10, W=5; 3-cycle high pulse: no gate, sort_cnt_o=0. Then a 6-cycle high pulse: gate_o rises at E+15, stays high 5 cycles, asg_trig_o 1 cycle.
- D=100, W=50, H=20; second rise 30 cycles after the first: one actuation only, sort_cnt_o=1, drop_cnt_o=1 (0 with the macro undefined).
- sort_trig_i held high 1000 cycles, M=1, D=0, W=2, H=0: exactly one actuation.
- Deassert enable_i during PULSE: gate_o low one cycle later, FSM in IDLE, sort_cnt_o unchanged. Assert adc_rst_i during DELAY: all outputs 0 next cycle.
- Preload 2^CW-1 actuations, then one more event: sort_cnt_o wraps to 0. drop_cnt_o at all-ones plus a further drop stays all-ones.
